// File: rtl/board_pkg.sv
// Shared types and constants for the Triangles-vs-Circles move arbiter.
// The ADJACENCY_RULE_EN build adds the ST_CHECK_ADJ state and the NOT_ADJACENT reason.
package board_pkg;

  localparam int BOARD_DIM_DEF  = 10;
  localparam int MAX_PIECES_DEF = 8;

  typedef enum logic [1:0] {
    CELL_EMPTY    = 2'd0,
    CELL_TRIANGLE = 2'd1,
    CELL_CIRCLE   = 2'd2
  } cell_t;

  typedef enum logic {
    PLAYER_TRIANGLE = 1'b0,
    PLAYER_CIRCLE   = 1'b1
  } player_t;

  localparam logic [2:0] REASON_NONE          = 3'd0;
  localparam logic [2:0] REASON_OUT_OF_BOUNDS = 3'd1;
  localparam logic [2:0] REASON_OCCUPIED      = 3'd2;
  localparam logic [2:0] REASON_GAME_OVER     = 3'd3;
  localparam logic [2:0] REASON_NOT_ADJACENT  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_COMMIT    = 3'd2,
    ST_REJECT    = 3'd3,
    ST_OVER      = 3'd4,
    ST_CHECK_ADJ = 3'd5
  } state_t;

  function automatic logic [1:0] player_cell(input player_t player);
    return (player == PLAYER_CIRCLE) ? CELL_CIRCLE : CELL_TRIANGLE;
  endfunction

endpackage

// File: rtl/board_mem.sv
// Board storage: BOARD_DIM x BOARD_DIM 2-bit cells, one write port, display and CHECK read ports.
// With ADJACENCY_RULE_EN defined it also returns the four orthogonal neighbours of the CHECK cell.
module board_mem
  import board_pkg::*;
#(
  parameter int BOARD_DIM = BOARD_DIM_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       we_i,
  input  logic [3:0] wr_x_i,
  input  logic [3:0] wr_y_i,
  input  logic [1:0] wr_cell_i,
  input  logic [3:0] rd_x_i,
  input  logic [3:0] rd_y_i,
  output logic [1:0] rd_cell_o,
  input  logic [3:0] chk_x_i,
  input  logic [3:0] chk_y_i,
  output logic [1:0] chk_cell_o
`ifdef ADJACENCY_RULE_EN
  ,
  output logic [7:0] nb_cells_o
`endif
);

  localparam int NCELL = BOARD_DIM * BOARD_DIM;

  logic [1:0]         cells_q [NCELL];
  logic [2*NCELL-1:0] cells_flat;

  // Coordinates are 5 bits wide so that an edge neighbour (-1 or +1) falls outside the board.
  function automatic logic [1:0] cell_at(input logic [2*NCELL-1:0] flat,
                                         input logic [4:0] cx,
                                         input logic [4:0] cy);
    logic [1:0] res;
    res = CELL_EMPTY;
    for (int yy = 0; yy < BOARD_DIM; yy++) begin
      for (int xx = 0; xx < BOARD_DIM; xx++) begin
        if (cx == 5'(xx) && cy == 5'(yy)) res = flat[2*(yy*BOARD_DIM+xx) +: 2];
      end
    end
    return res;
  endfunction

  for (genvar gi = 0; gi < NCELL; gi++) begin : g_cell
    localparam logic [3:0] CX = 4'(gi % BOARD_DIM);
    localparam logic [3:0] CY = 4'(gi / BOARD_DIM);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cells_q[gi] <= CELL_EMPTY;
      end else if (we_i && wr_x_i == CX && wr_y_i == CY) begin
        cells_q[gi] <= wr_cell_i;
      end
    end

    assign cells_flat[2*gi +: 2] = cells_q[gi];
  end

  assign rd_cell_o  = cell_at(cells_flat, {1'b0, rd_x_i}, {1'b0, rd_y_i});
  assign chk_cell_o = cell_at(cells_flat, {1'b0, chk_x_i}, {1'b0, chk_y_i});

`ifdef ADJACENCY_RULE_EN
  logic [4:0] chk_x5;
  logic [4:0] chk_y5;

  assign chk_x5 = {1'b0, chk_x_i};
  assign chk_y5 = {1'b0, chk_y_i};

  assign nb_cells_o[1:0] = cell_at(cells_flat, chk_x5 - 5'd1, chk_y5);
  assign nb_cells_o[3:2] = cell_at(cells_flat, chk_x5 + 5'd1, chk_y5);
  assign nb_cells_o[5:4] = cell_at(cells_flat, chk_x5, chk_y5 - 5'd1);
  assign nb_cells_o[7:6] = cell_at(cells_flat, chk_x5, chk_y5 + 5'd1);
`endif

endmodule

// File: rtl/board_move_arbiter.sv
// Turns coordinate requests into moves: legality check, commit, turn alternation and game-over.
// Define ADJACENCY_RULE_EN to require each non-first move to touch one of the mover's own pieces.
module board_move_arbiter
  import board_pkg::*;
#(
  parameter int BOARD_DIM  = BOARD_DIM_DEF,
  parameter int MAX_PIECES = MAX_PIECES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] x_in,
  input  logic [3:0] y_in,
  input  logic       coord_valid,
  input  logic [3:0] rd_x,
  input  logic [3:0] rd_y,
  output logic [1:0] rd_cell,
  output logic       current_player,
  output logic       move_accepted,
  output logic       move_rejected,
  output logic [2:0] reject_reason,
  output logic [3:0] triangle_count,
  output logic [3:0] circle_count,
  output logic       game_over
);

  localparam logic [4:0] DIM5 = 5'(BOARD_DIM);
  localparam logic [3:0] MAX4 = 4'(MAX_PIECES);

  state_t     state_q, state_d;
  logic [3:0] x_q, x_d;
  logic [3:0] y_q, y_d;
  player_t    player_q, player_d;
  logic [3:0] tri_cnt_q, tri_cnt_d;
  logic [3:0] cir_cnt_q, cir_cnt_d;
  logic       acc_q, acc_d;
  logic       rej_q, rej_d;
  logic [2:0] reason_q, reason_d;
  logic [2:0] pend_q, pend_d;
  logic       over_q, over_d;
  logic       coord_valid_q;

  logic       request;
  logic       mem_we;
  logic [1:0] own_cell;
  logic [1:0] chk_cell;

  assign request  = coord_valid & ~coord_valid_q;
  assign own_cell = player_cell(player_q);

`ifdef ADJACENCY_RULE_EN
  logic [7:0] nb_cells;
  logic       has_neighbour;
  logic [3:0] own_count;

  assign own_count = (player_q == PLAYER_CIRCLE) ? cir_cnt_q : tri_cnt_q;

  always_comb begin
    has_neighbour = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (nb_cells[2*i +: 2] == own_cell) has_neighbour = 1'b1;
    end
  end
`endif

  board_mem #(
    .BOARD_DIM (BOARD_DIM)
  ) u_mem (
    .clk        (clk),
    .reset_n    (reset_n),
    .we_i       (mem_we),
    .wr_x_i     (x_q),
    .wr_y_i     (y_q),
    .wr_cell_i  (own_cell),
    .rd_x_i     (rd_x),
    .rd_y_i     (rd_y),
    .rd_cell_o  (rd_cell),
    .chk_x_i    (x_q),
    .chk_y_i    (y_q),
    .chk_cell_o (chk_cell)
`ifdef ADJACENCY_RULE_EN
    ,
    .nb_cells_o (nb_cells)
`endif
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    player_d  = player_q;
    tri_cnt_d = tri_cnt_q;
    cir_cnt_d = cir_cnt_q;
    acc_d     = 1'b0;
    rej_d     = 1'b0;
    reason_d  = reason_q;
    pend_d    = pend_q;
    over_d    = over_q;
    mem_we    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (request) begin
          x_d     = x_in;
          y_d     = y_in;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // A finished game routes through CHECK only to give its rejection the usual two-cycle timing.
        if (over_q) begin
          pend_d  = REASON_GAME_OVER;
          state_d = ST_REJECT;
        end else if ({1'b0, x_q} >= DIM5 || {1'b0, y_q} >= DIM5) begin
          pend_d  = REASON_OUT_OF_BOUNDS;
          state_d = ST_REJECT;
        end else if (chk_cell != CELL_EMPTY) begin
          pend_d  = REASON_OCCUPIED;
          state_d = ST_REJECT;
        end else begin
`ifdef ADJACENCY_RULE_EN
          state_d = ST_CHECK_ADJ;
`else
          state_d = ST_COMMIT;
`endif
        end
      end
`ifdef ADJACENCY_RULE_EN
      ST_CHECK_ADJ: begin
        if (own_count == 4'd0 || has_neighbour) begin
          state_d = ST_COMMIT;
        end else begin
          pend_d  = REASON_NOT_ADJACENT;
          state_d = ST_REJECT;
        end
      end
`endif
      ST_COMMIT: begin
        mem_we   = 1'b1;
        acc_d    = 1'b1;
        reason_d = REASON_NONE;
        if (player_q == PLAYER_CIRCLE) begin
          cir_cnt_d = cir_cnt_q + 4'd1;
          player_d  = PLAYER_TRIANGLE;
        end else begin
          tri_cnt_d = tri_cnt_q + 4'd1;
          player_d  = PLAYER_CIRCLE;
        end
        if (tri_cnt_d == MAX4 && cir_cnt_d == MAX4) begin
          over_d  = 1'b1;
          state_d = ST_OVER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REJECT: begin
        rej_d    = 1'b1;
        reason_d = pend_q;
        state_d  = over_q ? ST_OVER : ST_IDLE;
      end
      ST_OVER: begin
        if (request) state_d = ST_CHECK;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      x_q           <= 4'd0;
      y_q           <= 4'd0;
      player_q      <= PLAYER_TRIANGLE;
      tri_cnt_q     <= 4'd0;
      cir_cnt_q     <= 4'd0;
      acc_q         <= 1'b0;
      rej_q         <= 1'b0;
      reason_q      <= REASON_NONE;
      pend_q        <= REASON_NONE;
      over_q        <= 1'b0;
      coord_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      player_q      <= player_d;
      tri_cnt_q     <= tri_cnt_d;
      cir_cnt_q     <= cir_cnt_d;
      acc_q         <= acc_d;
      rej_q         <= rej_d;
      reason_q      <= reason_d;
      pend_q        <= pend_d;
      over_q        <= over_d;
      coord_valid_q <= coord_valid;
    end
  end

  assign current_player = player_q;
  assign move_accepted  = acc_q;
  assign move_rejected  = rej_q;
  assign reject_reason  = reason_q;
  assign triangle_count = tri_cnt_q;
  assign circle_count   = cir_cnt_q;
  assign game_over      = over_q;

endmodule

// File: tb/tb_board_move_arbiter.sv
// Self-checking bench for board_move_arbiter: directed scenarios plus random requests
// compared against a board/turn model; honours ADJACENCY_RULE_EN when defined.
module tb_board_move_arbiter;

  localparam int DIM  = 10;
  localparam int MAXP = 8;
`ifdef ADJACENCY_RULE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] x_in = 4'd0;
  logic [3:0] y_in = 4'd0;
  logic       coord_valid = 1'b0;
  logic [3:0] rd_x = 4'd0;
  logic [3:0] rd_y = 4'd0;
  logic [1:0] rd_cell;
  logic       current_player;
  logic       move_accepted;
  logic       move_rejected;
  logic [2:0] reject_reason;
  logic [3:0] triangle_count;
  logic [3:0] circle_count;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  int m_board [16][16];
  int m_player;
  int m_tri;
  int m_cir;
  int m_over;

  always #5 clk = ~clk;

  board_move_arbiter #(
    .BOARD_DIM  (DIM),
    .MAX_PIECES (MAXP)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .x_in           (x_in),
    .y_in           (y_in),
    .coord_valid    (coord_valid),
    .rd_x           (rd_x),
    .rd_y           (rd_y),
    .rd_cell        (rd_cell),
    .current_player (current_player),
    .move_accepted  (move_accepted),
    .move_rejected  (move_rejected),
    .reject_reason  (reject_reason),
    .triangle_count (triangle_count),
    .circle_count   (circle_count),
    .game_over      (game_over)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++) m_board[yy][xx] = 0;
    m_player = 0;
    m_tri    = 0;
    m_cir    = 0;
    m_over   = 0;
  endfunction

  function automatic int model_cell(input int x, input int y);
    if (x >= DIM || y >= DIM) return 0;
    return m_board[y][x];
  endfunction

  function automatic bit model_adjacent_ok(input int x, input int y);
    int own;
    own = m_player + 1;
    if ((m_player == 0 ? m_tri : m_cir) == 0) return 1'b1;
    if (x > 0       && m_board[y][x-1] == own) return 1'b1;
    if (x < DIM - 1 && m_board[y][x+1] == own) return 1'b1;
    if (y > 0       && m_board[y-1][x] == own) return 1'b1;
    if (y < DIM - 1 && m_board[y+1][x] == own) return 1'b1;
    return 1'b0;
  endfunction

  // Outcome of a request at (x,y) given the current board: accepted, or the refusal reason.
  function automatic void model_eval(input int x, input int y, output bit acc, output int reason);
    acc    = 1'b0;
    reason = 0;
    if (m_over != 0) reason = 3;
    else if (x >= DIM || y >= DIM) reason = 1;
    else if (m_board[y][x] != 0) reason = 2;
`ifdef ADJACENCY_RULE_EN
    else if (!model_adjacent_ok(x, y)) reason = 4;
`endif
    else acc = 1'b1;
  endfunction

  function automatic void model_apply(input int x, input int y);
    m_board[y][x] = m_player + 1;
    if (m_player == 0) m_tri++;
    else m_cir++;
    m_player = 1 - m_player;
    if (m_tri == MAXP && m_cir == MAXP) m_over = 1;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    coord_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic check_cell(input string tag, input int x, input int y);
    rd_x = 4'(x);
    rd_y = 4'(y);
    #1;
    check_eq(tag, int'(rd_cell), model_cell(x, y));
  endtask

  task automatic scan_board(input string tag);
    int mism;
    mism = 0;
    for (int yy = 0; yy < 16; yy++) begin
      for (int xx = 0; xx < 16; xx++) begin
        rd_x = 4'(xx);
        rd_y = 4'(yy);
        #1;
        if (int'(rd_cell) != model_cell(xx, yy)) mism++;
      end
    end
    check_eq(tag, mism, 0);
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_player"}, int'(current_player), m_player);
    check_eq({tag, "_tri"}, int'(triangle_count), m_tri);
    check_eq({tag, "_cir"}, int'(circle_count), m_cir);
    check_eq({tag, "_over"}, int'(game_over), m_over);
  endtask

  // mode 0: single rising edge; mode 1: level held 20 cycles; mode 2: second rise two cycles in.
  task automatic do_request(input int x, input int y, input int mode);
    bit exp_acc;
    int exp_reason, exp_lat, acc_at, rej_at, pulses, ncyc;
    model_eval(x, y, exp_acc, exp_reason);
    exp_lat = (exp_reason == 3) ? 2 : LAT;
    ncyc    = (mode == 1) ? 24 : LAT + 3;
    x_in = 4'(x);
    y_in = 4'(y);
    coord_valid = 1'b1;
    @(posedge clk);
    #1;
    x_in = 4'($urandom);
    y_in = 4'($urandom);
    acc_at = 0;
    rej_at = 0;
    pulses = 0;
    for (int c = 1; c <= ncyc; c++) begin
      case (mode)
        1:       coord_valid = (c < 20);
        2:       coord_valid = (c == 2);
        default: coord_valid = 1'b0;
      endcase
      @(posedge clk);
      #1;
      if (move_accepted) begin
        if (acc_at == 0) acc_at = c;
        pulses++;
      end
      if (move_rejected) begin
        if (rej_at == 0) rej_at = c;
        pulses++;
      end
    end
    coord_valid = 1'b0;
    if (exp_acc) begin
      check_eq("accept_latency", acc_at, exp_lat);
      check_eq("no_reject", rej_at, 0);
      model_apply(x, y);
    end else begin
      check_eq("reject_latency", rej_at, exp_lat);
      check_eq("no_accept", acc_at, 0);
    end
    check_eq("pulse_count", pulses, 1);
    check_eq("reason", int'(reject_reason), exp_reason);
    check_state("post");
    check_cell("target_cell", x, y);
    $display("REQ x=%0d y=%0d mode=%0d acc=%0d reason=%0d player=%0d tri=%0d cir=%0d over=%0d",
             x, y, mode, exp_acc, exp_reason, m_player, m_tri, m_cir, m_over);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int lx, ly;

    do_reset();
    check_state("reset");
    check_eq("reset_acc", int'(move_accepted), 0);
    check_eq("reset_rej", int'(move_rejected), 0);
    check_eq("reset_reason", int'(reject_reason), 0);
    scan_board("reset_board");

    do_request(3, 4, 0);
    do_request(3, 4, 0);
    do_request(10, 0, 0);
    check_cell("board_kept", 3, 4);
    do_request(3, 5, 1);
    do_request(4, 4, 2);
    scan_board("directed_board");

    // Reset between the request and its pulse must abort the move.
    x_in = 4'd1;
    y_in = 4'd1;
    coord_valid = 1'b1;
    @(posedge clk);
    #1;
    coord_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    model_reset();
    pulses = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      pulses += int'(move_accepted) + int'(move_rejected);
    end
    reset_n = 1'b1;
    repeat (LAT + 2) begin
      @(posedge clk);
      #1;
      pulses += int'(move_accepted) + int'(move_rejected);
    end
    check_eq("abort_pulses", pulses, 0);
    check_state("abort");
    scan_board("abort_board");

`ifdef ADJACENCY_RULE_EN
    do_request(0, 0, 0);
    do_request(5, 5, 0);
    do_request(2, 2, 0);
    do_request(1, 0, 0);
`endif

    do_reset();
    for (int i = 0; i < MAXP; i++) begin
      do_request(i, 0, 0);
      do_request(i, DIM - 1, 0);
    end
    check_eq("game_over_set", int'(game_over), 1);
    do_request(5, 5, 0);
    do_request(12, 3, 0);
    scan_board("over_board");

    do_reset();
    lx = 0;
    ly = 0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        lx = $urandom_range(0, 11);
        ly = $urandom_range(0, 11);
      end
      do_request(lx, ly, 0);
    end
    scan_board("random_board");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
